// File: rtl/mux_nto1_reg.sv
// N-input registered multiplexer with valid/ready on every channel and on the output.
// MODE=0 selects by sel; MODE=1 round-robins among valid inputs starting after the last grant.
module mux_nto1_reg #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = 2,
    parameter int MODE  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   grant
);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [SEL_W-1:0] r_grant;
    logic [SEL_W-1:0] r_ptr;

    logic             w_can_load;
    logic             w_xfer;
    logic             w_pick_vld;
    logic             w_rr_hit;
    logic [SEL_W-1:0] w_sel_eff;
    logic [SEL_W-1:0] w_rr_idx;
    logic [SEL_W-1:0] w_cand;
    logic [SEL_W-1:0] w_pick;
    logic [WIDTH-1:0] w_pick_data;

    assign w_can_load = !r_valid | out_ready;

    // Out-of-range selects fall through to the last channel.
    assign w_sel_eff = (int'(sel) < N) ? sel : LAST;

    // First valid channel after the pointer, wrapping modulo N.
    always_comb begin
        w_rr_idx = r_ptr;
        w_rr_hit = 1'b0;
        w_cand   = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = SEL_W'((int'(r_ptr) + k) % N);
            if (!w_rr_hit && in_valid[w_cand]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = w_cand;
            end
        end
    end

    assign w_pick      = (MODE == 1) ? w_rr_idx : w_sel_eff;
    assign w_pick_vld  = (MODE == 1) ? w_rr_hit : in_valid[w_pick];
    assign w_pick_data = in_data[int'(w_pick)*WIDTH +: WIDTH];
    assign w_xfer      = w_can_load & w_pick_vld;

    // In select mode the chosen channel sees ready even while it is idle.
    always_comb begin
        in_ready = '0;
        if (w_can_load && (MODE == 0 || w_rr_hit))
            in_ready[w_pick] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_grant <= '0;
            r_ptr   <= LAST;
        end else if (w_xfer) begin
            r_data  <= w_pick_data;
            r_valid <= 1'b1;
            r_grant <= w_pick;
            r_ptr   <= w_pick;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign grant     = r_grant;
endmodule
